// File: rtl/ws2812_pkg.sv
// Shared types and default WS2812 timing for the frame sequencer slice.
// Timing defaults assume a 50 MHz clock.
package ws2812_pkg;

   localparam int unsigned PIXEL_W       = 24;
   localparam int unsigned DEF_BIT_CYC   = 62;
   localparam int unsigned DEF_T0H_CYC   = 20;
   localparam int unsigned DEF_T1H_CYC   = 40;
   localparam int unsigned DEF_RESET_CYC = 3000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_LATCH,
      S_DONE
   } state_e;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// WS2812 bit serialiser: shift register plus shadow word, bit-slot counter
// and high-time compare driving the LED control line.
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int unsigned BIT_CYC = DEF_BIT_CYC,
   parameter int unsigned T0H_CYC = DEF_T0H_CYC,
   parameter int unsigned T1H_CYC = DEF_T1H_CYC
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [PIXEL_W-1:0] load_word_i,
   input  logic               shadow_wr_i,
   input  logic [PIXEL_W-1:0] shadow_word_i,
   input  logic               next_word_i,
   output logic               word_start_o,
   output logic               word_done_o,
   output logic               led_ctl_o
);

   localparam int unsigned      CNT_W    = $clog2(BIT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] T0H_L    = CNT_W'(T0H_CYC);
   localparam logic [CNT_W-1:0] T1H_L    = CNT_W'(T1H_CYC);
   localparam int unsigned      IDX_W    = $clog2(PIXEL_W);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PIXEL_W - 1);

   logic               active_q;
   logic [PIXEL_W-1:0] shift_q;
   logic [PIXEL_W-1:0] shadow_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               bit_end;

   assign bit_end      = active_q && (cnt_q == CNT_LAST);
   assign word_done_o  = bit_end && (idx_q == '0);
   assign word_start_o = active_q && (idx_q == IDX_TOP) && (cnt_q == '0);
   // Combinational so an asynchronous reset drops the line immediately.
   assign led_ctl_o    = active_q && (cnt_q < (shift_q[PIXEL_W-1] ? T1H_L : T0H_L));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         shift_q  <= '0;
         shadow_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         if (shadow_wr_i) begin
            shadow_q <= shadow_word_i;
         end
         if (load_i) begin
            shift_q  <= load_word_i;
            idx_q    <= IDX_TOP;
            cnt_q    <= '0;
            active_q <= 1'b1;
         end else if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == '0) begin
               // Shadow word follows on the very next clock: no inter-pixel gap.
               if (next_word_i) begin
                  shift_q <= shadow_q;
                  idx_q   <= IDX_TOP;
               end else begin
                  active_q <= 1'b0;
               end
            end else begin
               idx_q   <= idx_q - 1'b1;
               shift_q <= {shift_q[PIXEL_W-2:0], 1'b0};
            end
         end else if (active_q) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// WS2812 frame sequencer: fetches LED_COUNT pixel words with one-pixel
// prefetch, streams them through the bit encoder, then holds the latch period.
module ws2812_frame_sequencer
   import ws2812_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
   parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
   parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
   parameter int unsigned RESET_CYC = DEF_RESET_CYC
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [ADDR_W-1:0]  led_count_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               rd_en_o,
   output logic [ADDR_W-1:0]  rd_addr_o,
   input  logic [PIXEL_W-1:0] rd_data_i,
   output logic               led_ctl_o
);

   generate
      if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC > 0)) begin : g_bad_timing
         $error("ws2812_frame_sequencer: need 0 < T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC > 0");
      end
   endgenerate

   localparam int unsigned      LAT_W    = $clog2(RESET_CYC + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYC - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] count_q;
   logic [ADDR_W-1:0] pix_q;
   logic [LAT_W-1:0]  lat_cnt_q;
   logic              pf_q;
   logic              more;
   logic              prefetch;
   logic              enc_load;
   logic              word_start;
   logic              word_done;

   assign more      = (pix_q + 1'b1) != count_q;
   assign busy_o    = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                      (state_q == S_SHIFT) || (state_q == S_LATCH);
   // While shifting pixel n the only address ever needed is the prefetch of n+1.
   assign rd_addr_o = (state_q == S_SHIFT) ? pix_q + 1'b1 : '0;

   always_comb begin
      state_d  = state_q;
      rd_en_o  = 1'b0;
      enc_load = 1'b0;
      done_o   = 1'b0;
      prefetch = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && (led_count_i != '0)) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            rd_en_o = 1'b1;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            enc_load = 1'b1;
            state_d  = S_SHIFT;
         end
         S_SHIFT: begin
            prefetch = word_start && more;
            rd_en_o  = prefetch;
            if (word_done && !more) begin
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         pix_q     <= '0;
         lat_cnt_q <= '0;
         pf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pf_q      <= prefetch;
         lat_cnt_q <= (state_q == S_LATCH) ? lat_cnt_q + 1'b1 : '0;
         if ((state_q == S_IDLE) && (state_d == S_FETCH)) begin
            count_q <= led_count_i;
         end
         if (state_q == S_LOAD) begin
            pix_q <= '0;
         end else if ((state_q == S_SHIFT) && word_done && more) begin
            pix_q <= pix_q + 1'b1;
         end
      end
   end

   ws2812_bit_encoder #(
      .BIT_CYC (BIT_CYC),
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC)
   ) u_enc (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .load_i        (enc_load),
      .load_word_i   (rd_data_i),
      .shadow_wr_i   (pf_q),
      .shadow_word_i (rd_data_i),
      .next_word_i   (more),
      .word_start_o  (word_start),
      .word_done_o   (word_done),
      .led_ctl_o     (led_ctl_o)
   );

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer with shortened timing.
module tb_ws2812_frame_sequencer;

   localparam int unsigned AW = 8;
   localparam int BC = 10;
   localparam int T0 = 3;
   localparam int T1 = 7;
   localparam int RC = 50;

   logic          clk;
   logic          rst_i;
   logic          start_i;
   logic [AW-1:0] led_count_i;
   logic          busy_o;
   logic          done_o;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   logic [23:0]   rd_data_i;
   logic          led_ctl_o;

   int checks = 0;
   int errors = 0;

   logic [23:0] mem [0:255];
   int          reads[$];
   bit          led_a  [0:1023];
   bit          busy_a [0:1023];

   typedef struct {
      int          cnt;
      logic [23:0] w0;
      logic [23:0] w1;
      logic [23:0] w2;
      int          exp_done;
      int          inj_cyc;
      bit          start_on_done;
   } vec_t;

   vec_t tbl [4];

   ws2812_frame_sequencer #(
      .ADDR_W    (AW),
      .BIT_CYC   (BC),
      .T0H_CYC   (T0),
      .T1H_CYC   (T1),
      .RESET_CYC (RC)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .led_count_i (led_count_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .rd_data_i   (rd_data_i),
      .led_ctl_o   (led_ctl_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pixel RAM model: data one clock after the strobe.
   always @(posedge clk) begin
      if (rd_en_o) begin
         rd_data_i <= mem[rd_addr_o];
         reads.push_back(int'(rd_addr_o));
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          done_cyc;
      int          lim;
      int          any;
      logic [23:0] w [3];
      logic [BC-1:0] act_p;
      logic [BC-1:0] exp_p;
      int          s;
      int          thr;
      done_cyc = -1;
      lim = (v.exp_done > 0) ? v.exp_done + 20 : 40;
      w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
      mem[0] = v.w0; mem[1] = v.w1; mem[2] = v.w2;
      for (int i = 0; i < 1024; i++) begin
         led_a[i] = 1'b0;
         busy_a[i] = 1'b0;
      end
      @(posedge clk); #1;
      reads.delete();
      start_i = 1'b1;
      led_count_i = AW'(v.cnt);
      for (int c = 0; c < lim; c++) begin
         @(negedge clk);
         led_a[c] = led_ctl_o;
         busy_a[c] = busy_o;
         if (done_o) begin
            done_cyc = c;
            break;
         end
         @(posedge clk); #1;
         start_i = (c + 1 == v.inj_cyc) || (v.start_on_done && (c + 1 == v.exp_done));
         if (c + 1 == v.inj_cyc) led_count_i = 8'd5;
      end
      if (v.cnt == 0) begin
         any = 0;
         for (int i = 0; i < lim; i++) any = any | int'(busy_a[i]);
         chk("zero_count_busy", any, 0);
         chk("zero_count_reads", reads.size(), 0);
         chk("zero_count_done", done_cyc, -1);
      end else begin
         chk("busy_in_start_cycle", busy_a[0], 0);
         chk("busy_after_start", busy_a[1], 1);
         chk("done_cycle", done_cyc, v.exp_done);
         for (int p = 0; p < v.cnt; p++) begin
            for (int b = 0; b < 24; b++) begin
               s = 3 + (p * 24 + b) * BC;
               thr = w[p][23 - b] ? T1 : T0;
               for (int k = 0; k < BC; k++) begin
                  act_p[k] = led_a[s + k];
                  exp_p[k] = (k < thr);
               end
               chk($sformatf("bit_wave_p%0d_b%0d", p, b), act_p, exp_p);
            end
         end
         if (done_cyc >= 0) begin
            chk("busy_in_done_cycle", busy_a[done_cyc], 0);
            any = 0;
            for (int i = 3 + 24 * BC * v.cnt; i <= done_cyc; i++) any = any | int'(led_a[i]);
            chk("latch_low", any, 0);
         end
         chk("read_count", reads.size(), v.cnt);
         for (int i = 0; i < reads.size(); i++) chk($sformatf("read_addr_%0d", i), reads[i], i);
      end
   endtask

   initial begin
      int seen;
      int rel;
      vec_t v;
      rst_i = 1'b1;
      start_i = 1'b0;
      led_count_i = '0;
      for (int i = 0; i < 256; i++) mem[i] = 24'h5A5A00 | 24'(i);

      tbl[0] = '{cnt: 1, w0: 24'hA50000, w1: 24'h0, w2: 24'h0, exp_done: 293, inj_cyc: -1, start_on_done: 0};
      tbl[1] = '{cnt: 3, w0: 24'hFFFFFF, w1: 24'h000000, w2: 24'h800001, exp_done: 773, inj_cyc: 100, start_on_done: 0};
      tbl[2] = '{cnt: 0, w0: 24'h123456, w1: 24'h0, w2: 24'h0, exp_done: -1, inj_cyc: -1, start_on_done: 0};
      tbl[3] = '{cnt: 2, w0: 24'h123456, w1: 24'hFEDCBA, w2: 24'h0, exp_done: 533, inj_cyc: 250, start_on_done: 0};

      repeat (2) @(negedge clk);
      chk("rst_led", led_ctl_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_rd_addr", rd_addr_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;

      for (int t = 0; t < 4; t++) begin
         run_vec(tbl[t]);
         repeat (3) @(posedge clk);
      end

      // Asynchronous reset in the high phase of a '1' bit.
      mem[0] = 24'hFFFFFF;
      mem[1] = 24'hFFFFFF;
      @(posedge clk); #1;
      reads.delete();
      start_i = 1'b1;
      led_count_i = 8'd2;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("led_high_before_rst", led_ctl_o, 1);
      #2 rst_i = 1'b1;
      #1;
      chk("led_low_on_rst", led_ctl_o, 0);
      chk("busy_low_on_rst", busy_o, 0);
      chk("reads_before_rst", reads.size(), 2);
      @(posedge clk); #1;
      rst_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         seen = seen | int'(done_o) | int'(busy_o) | int'(led_ctl_o);
      end
      chk("quiet_after_rst", seen, 0);

      // Fresh frame after reset must start at address 0.
      v = '{cnt: 1, w0: 24'h0F00F0, w1: 24'h0, w2: 24'h0, exp_done: 293, inj_cyc: -1, start_on_done: 0};
      run_vec(v);
      repeat (3) @(posedge clk);

      // Start during the done cycle is dropped; the next cycle's start is taken.
      v = '{cnt: 1, w0: 24'h00FF00, w1: 24'h0, w2: 24'h0, exp_done: 293, inj_cyc: -1, start_on_done: 1};
      run_vec(v);
      @(posedge clk); #1;
      start_i = 1'b1;
      @(negedge clk);
      chk("start_in_done_ignored_busy", busy_o, 0);
      chk("start_in_done_ignored_rd_en", rd_en_o, 0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      chk("late_start_busy", busy_o, 1);
      chk("late_start_rd_en", rd_en_o, 1);
      chk("late_start_rd_addr", rd_addr_o, 0);
      rel = -1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (done_o) begin
            rel = n + 2;
            break;
         end
      end
      chk("late_start_done_cycle", rel, 293);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
